// File: rtl/rbr_pkg.sv
// rtl/rbr_pkg.sv - RBR digit encodings, slot state type and shared helper functions
package rbr_pkg;

  localparam logic [1:0] RBR_NEG      = 2'b00;
  localparam logic [1:0] RBR_ZERO     = 2'b01;
  localparam logic [1:0] RBR_ZERO_ALT = 2'b10;
  localparam logic [1:0] RBR_POS      = 2'b11;

  localparam int RBR_MAXW = 512;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  function automatic int rbr_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

  function automatic logic [2*RBR_MAXW-1:0] rbr_zero(input int w);
    logic [2*RBR_MAXW-1:0] z;
    z = '0;
    for (int i = 0; i < RBR_MAXW; i++) begin
      if (i < w) z[2*i +: 2] = RBR_ZERO;
    end
    return z;
  endfunction

  function automatic logic signed [1:0] rbr_decode(input logic [1:0] d);
    case (d)
      RBR_NEG:                return 2'b11;
      RBR_ZERO, RBR_ZERO_ALT: return 2'b00;
      RBR_POS:                return 2'b01;
      default:                return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] rbr_encode(input logic signed [1:0] v);
    case (v)
      2'b11:   return RBR_NEG;
      2'b01:   return RBR_POS;
      default: return RBR_ZERO;
    endcase
  endfunction

  // Transfer out of a digit whose pair sum is p; lo_nonneg says the next lower pair sum is >= 0,
  // which bounds the incoming transfer so that interim + transfer always stays within one digit.
  function automatic logic signed [1:0] rbr_xfer(input logic signed [2:0] p, input logic lo_nonneg);
    case (p)
      3'b010:  return 2'b01;
      3'b110:  return 2'b11;
      3'b001:  return lo_nonneg ? 2'b01 : 2'b00;
      3'b111:  return lo_nonneg ? 2'b00 : 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic signed [1:0] rbr_interim(input logic signed [2:0] p, input logic lo_nonneg);
    case (p)
      3'b001, 3'b111: return lo_nonneg ? 2'b11 : 2'b01;
      default:        return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/rbr_add.sv
// rtl/rbr_add.sv - carry-free redundant binary adder, MS transfer discarded (sum modulo 2^W)
module rbr_add
  import rbr_pkg::*;
#(
  parameter int W = 64
) (
  input  logic [2*W-1:0] i_a,
  input  logic [2*W-1:0] i_b,
  output logic [2*W-1:0] o_s
);

  logic [W-1:0][2:0] w_p;
  logic [W-1:0][1:0] w_t;
  logic [W-1:0]      w_lo_nonneg;

  assign w_t[0]         = 2'b00;
  assign w_lo_nonneg[0] = 1'b1;

  for (genvar i = 0; i < W; i++) begin : g_digit
    logic signed [1:0] w_da;
    logic signed [1:0] w_db;
    logic signed [1:0] w_w;

    assign w_da          = rbr_decode(i_a[2*i +: 2]);
    assign w_db          = rbr_decode(i_b[2*i +: 2]);
    assign w_p[i]        = {w_da[1], w_da} + {w_db[1], w_db};
    assign w_w           = rbr_interim(w_p[i], w_lo_nonneg[i]);
    assign o_s[2*i +: 2] = rbr_encode(w_w + w_t[i]);

    if (i < W-1) begin : g_xfer
      assign w_lo_nonneg[i+1] = ~w_p[i][2];
      assign w_t[i+1]         = rbr_xfer(w_p[i], w_lo_nonneg[i]);
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin one-hot grant with pointer advancing past each accepted requester
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [NREQ-1:0] i_req,
  input  logic            i_en,
  output logic [NREQ-1:0] o_grant,
  output logic [IDW-1:0]  o_grant_idx
);

  logic [IDW-1:0] r_ptr;
  logic           w_found;
  logic [IDW-1:0] w_idx;

  always_comb begin
    int k;
    k       = 0;
    w_found = 1'b0;
    w_idx   = r_ptr;
    for (int j = 0; j < NREQ; j++) begin
      k = int'(r_ptr) + j;
      if (k >= NREQ) k = k - NREQ;
      if (!w_found && i_req[k]) begin
        w_found = 1'b1;
        w_idx   = IDW'(k);
      end
    end
    o_grant = '0;
    if (i_en && w_found) o_grant[w_idx] = 1'b1;
  end

  assign o_grant_idx = w_idx;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= '0;
    end else if (i_en && w_found) begin
      r_ptr <= (w_idx == IDW'(NREQ-1)) ? '0 : w_idx + 1'b1;
    end
  end

endmodule

// File: rtl/rbr_add_arb.sv
// rtl/rbr_add_arb.sv - shares one RBR adder among NREQ requesters with a single registered result slot
module rbr_add_arb
  import rbr_pkg::*;
#(
  parameter int  W    = 64,
  parameter int  NREQ = 4,
  localparam int IDW  = rbr_clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*2*W-1:0]  req_a,
  input  logic [NREQ*2*W-1:0]  req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [2*W-1:0]       rsp_s,
  output logic [IDW-1:0]       rsp_id,
  output logic                 busy
);

  localparam logic [2*W-1:0] S_RESET = (2*W)'(rbr_zero(W));

  slot_state_t                r_state;
  slot_state_t                w_state_nxt;
  logic [2*W-1:0]             r_s;
  logic [IDW-1:0]             r_id;
  logic                       w_can_accept;
  logic                       w_accept;
  logic [IDW-1:0]             w_gidx;
  logic [NREQ-1:0][2*W-1:0]   w_a_vec;
  logic [NREQ-1:0][2*W-1:0]   w_b_vec;
  logic [2*W-1:0]             w_a;
  logic [2*W-1:0]             w_b;
  logic [2*W-1:0]             w_sum;

  // The slot can take a new result when empty or when it drains this same cycle; reset blocks accepts.
  assign w_can_accept = ~rst & ((r_state == SLOT_EMPTY) | rsp_ready);
  assign w_accept     = |(req_valid & req_ready);

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req       (req_valid),
    .i_en        (w_can_accept),
    .o_grant     (req_ready),
    .o_grant_idx (w_gidx)
  );

  assign w_a_vec = req_a;
  assign w_b_vec = req_b;
  assign w_a     = w_a_vec[w_gidx];
  assign w_b     = w_b_vec[w_gidx];

  rbr_add #(
    .W (W)
  ) u_add (
    .i_a (w_a),
    .i_b (w_b),
    .o_s (w_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= SLOT_EMPTY;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      SLOT_EMPTY: if (w_accept) w_state_nxt = SLOT_FULL;
      SLOT_FULL:  if (!w_accept && rsp_ready) w_state_nxt = SLOT_EMPTY;
      default:    w_state_nxt = SLOT_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s  <= S_RESET;
      r_id <= '0;
    end else if (w_accept) begin
      r_s  <= w_sum;
      r_id <= w_gidx;
    end
  end

  assign rsp_valid = (r_state == SLOT_FULL);
  assign rsp_s     = r_s;
  assign rsp_id    = r_id;
  assign busy      = rsp_valid | (|req_valid);

endmodule

// File: tb/tb_rbr_add_arb.sv
// tb/tb_rbr_add_arb.sv - randomized scoreboard bench for rbr_add_arb (W=4, NREQ=4)
module tb_rbr_add_arb;

  localparam int W    = 4;
  localparam int NREQ = 4;
  localparam int DW   = 2*W;
  localparam int MODV = 1 << W;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*DW-1:0]   req_a;
  logic [NREQ*DW-1:0]   req_b;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [DW-1:0]        rsp_s;
  logic [1:0]           rsp_id;
  logic                 busy;

  always #5 clk = ~clk;

  rbr_add_arb #(.W(W), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_s     (rsp_s),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  typedef struct {
    int id;
    int sum;
  } exp_t;

  exp_t            sb[$];
  int              n_checks = 0;
  int              n_pass   = 0;
  logic [NREQ-1:0] v;
  logic [DW-1:0]   opa[NREQ];
  logic [DW-1:0]   opb[NREQ];
  int              ptr;
  int              mode;
  int              dut_grant;
  int              dut_grants[$];

  // Digit value is bit1 + bit0 - 1, weighted by 2^i.
  function automatic int rbr_val(input logic [DW-1:0] x);
    int s;
    s = 0;
    for (int i = 0; i < W; i++) s += (int'(x[2*i+1]) + int'(x[2*i]) - 1) * (1 << i);
    return s;
  endfunction

  function automatic int modw(input int x);
    return ((x % MODV) + MODV) % MODV;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic new_op(input int k);
    v[k]   = 1'b1;
    opa[k] = DW'($urandom);
    opb[k] = DW'($urandom);
  endtask

  always @(negedge clk) begin
    if (rst !== 1'b1 && rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("rsp_valid_extra", rsp_valid, 0);
      end else begin
        chk("rsp_id", rsp_id, sb[0].id);
        chk("rsp_s_mod", modw(rbr_val(rsp_s)), sb[0].sum);
        if (rsp_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic step(input bit r, input bit rr, input bit chk_rst_outs);
    bit exp_full;
    bit can;
    int gk;
    int k;
    logic [NREQ-1:0] exp_ready;
    @(posedge clk);
    #1;
    rst       = r;
    rsp_ready = rr;
    for (int j = 0; j < NREQ; j++) begin
      if (!v[j] && (mode == 1 || (mode == 2 && $urandom_range(0, 1) == 1))) new_op(j);
    end
    for (int j = 0; j < NREQ; j++) begin
      req_a[j*DW +: DW] = opa[j];
      req_b[j*DW +: DW] = opb[j];
    end
    req_valid = v;
    #3;
    dut_grant = -1;
    for (int j = 0; j < NREQ; j++) if (req_ready[j] === 1'b1) dut_grant = j;
    if (r) begin
      chk("rst_req_ready", req_ready, 0);
      if (chk_rst_outs) begin
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_s", rsp_s, 8'b01010101);
        chk("rst_rsp_id", rsp_id, 0);
      end
      sb.delete();
      ptr = 0;
    end else begin
      exp_full = (sb.size() != 0);
      chk("rsp_valid", rsp_valid, exp_full);
      chk("busy", busy, exp_full || (|v));
      can = !exp_full || rr;
      gk  = -1;
      if (can) begin
        for (int j = 0; j < NREQ; j++) begin
          k = (ptr + j) % NREQ;
          if (v[k] && gk < 0) gk = k;
        end
      end
      exp_ready = '0;
      if (gk >= 0) exp_ready[gk] = 1'b1;
      chk("req_ready", req_ready, exp_ready);
      if (gk >= 0) begin
        sb.push_back('{gk, modw(rbr_val(opa[gk]) + rbr_val(opb[gk]))});
        ptr   = (gk + 1) % NREQ;
        v[gk] = 1'b0;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    rsp_ready = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    mode      = 0;
    ptr       = 0;
    v         = '0;
    for (int j = 0; j < NREQ; j++) new_op(j);

    step(1, 0, 0);
    step(1, 0, 1);

    // Full load: expect strict rotation with a result every cycle.
    mode = 1;
    dut_grants.delete();
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 0);
      dut_grants.push_back(dut_grant);
    end
    for (int i = 0; i < 8; i++) chk($sformatf("rr_order_%0d", i), dut_grants[i], i % NREQ);
    mode = 0;
    v    = '0;
    step(0, 1, 0);

    // Single op from requester 2: +3 + +1.
    v[2]   = 1'b1;
    opa[2] = 8'b01011111;
    opb[2] = 8'b01010111;
    step(0, 1, 0);
    chk("single_grant", dut_grant, 2);
    step(0, 1, 0);

    // Back-pressure: pending result held for three cycles, then drain plus accept together.
    for (int j = 0; j < NREQ; j++) new_op(j);
    step(0, 1, 0);
    chk("bp_first_grant", dut_grant, 3);
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    step(0, 1, 0);
    chk("bp_drain_accept_grant", dut_grant, 0);
    v = '0;
    step(0, 1, 0);

    // Modular wrap and pointer wrap from requester 3.
    v[3]   = 1'b1;
    opa[3] = 8'b11111111;
    opb[3] = 8'b01010111;
    step(0, 1, 0);
    chk("wrap_grant", dut_grant, 3);
    for (int j = 0; j < NREQ; j++) new_op(j);
    step(0, 1, 0);
    chk("ptr_wrap_grant", dut_grant, 0);

    // Reset while a result is stalled.
    step(0, 0, 0);
    step(1, 0, 0);
    for (int j = 0; j < NREQ; j++) if (!v[j]) new_op(j);
    step(0, 1, 0);
    chk("post_reset_grant", dut_grant, 0);

    mode = 2;
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 79) == 0, $urandom_range(0, 3) != 0, 0);
    end

    mode = 0;
    v    = '0;
    for (int i = 0; i < 3; i++) step(0, 1, 0);
    chk("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rbr_add_arb.md
Name: rbr_add_arb

Overview:
- Round-robin arbiter and sequencer that shares one combinational RBR adder (rbr_add) between NREQ requesters in the BKM FPU datapath.
- Each requester presents an RBR operand pair over a valid/ready handshake.
- The block grants one requester per cycle, performs s=a+b, and returns the registered sum with the requester ID over a valid/ready response channel.
- Sits between the BKM iteration units (X/Y/E update paths) and the single shared adder instance.

Parameters:
- W, 64, word width in RBR digits; each operand is 2*W bits.
- NREQ, 4, number of requesters, 2..16.
- IDW, clog2(NREQ), width of the requester ID field (derived, not overridable).

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester operand valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high per cycle.
- req_a  in  NREQ*2*W  packed operand a; requester k occupies bits [k*2W +: 2W].
- req_b  in  NREQ*2*W  packed operand b, same packing as req_a.
- rsp_valid  out  1  result register holds a valid sum.
- rsp_ready  in  1  consumer accepts the result.
- rsp_s  out  2*W  registered RBR sum.
- rsp_id  out  IDW  index of the requester that produced rsp_s.
- busy  out  1  high when rsp_valid=1 or any req_valid=1.

Behaviour:
- Reset values: rsp_valid=0, rsp_s={W{2'b01}} (RBR zero), rsp_id=0, pointer=0, req_ready=0.
- Output slot FSM, states EMPTY and FULL:
  - EMPTY -> FULL on accept.
  - FULL -> FULL on drain plus accept in the same cycle.
  - FULL -> EMPTY on drain without accept.
- Drain occurs when rsp_valid & rsp_ready.
- can_accept = (state==EMPTY) | rsp_ready. When can_accept=0, all req_ready bits are 0.
- Grant is round-robin:
  - Search order is pointer, pointer+1, ..., wrapping mod NREQ.
  - The first requester with req_valid=1 gets req_ready=1, only if can_accept=1.
  - req_ready may depend combinationally on req_valid and rsp_ready.
  - An accept is req_valid[k] & req_ready[k].
- Pointer advances to (k+1) mod NREQ only on an accept; it is unchanged on idle or stall cycles. When k=NREQ-1, the pointer wraps to 0.
- Latency: an accept in cycle t gives rsp_valid=1 with the sum and rsp_id=k in cycle t+1. Sustained throughput is 1 op/cycle while rsp_ready=1.
- rsp_s and rsp_id are stable while rsp_valid=1 & rsp_ready=0. They load only on accept, and hold their value when idle.
- Arithmetic:
  - s = rbr_add(a,b), digit encoding 00=-1, 01/10=0, 11=+1.
  - The carry out of the MS digit is discarded, so the sum is modular in 2^W. Overflow handling is the requester's responsibility.
- Inputs are not registered. Requesters must hold req_a/req_b stable while req_valid=1 and not accepted, and must not drop req_valid before acceptance.
- Reset mid-operation: a pending result is discarded (rsp_valid=0), the pointer returns to 0, and the reset cycle accepts nothing.
- Simultaneous rst and accept: rst wins.
- No requester waits more than NREQ-1 accepts of other requesters once valid.

Decomposition:
- Package rbr_pkg:
  - Digit encodings RBR_NEG=2'b00, RBR_ZERO=2'b01, RBR_ZERO_ALT=2'b10, RBR_POS=2'b11.
  - Function rbr_zero(W) returning {W{RBR_ZERO}}.
  - clog2 helper.
  - Digit-decode function for benches.
- Sub-module rr_arbiter (NREQ, req vector, enable, grant one-hot, grant index, pointer register). rbr_add_arb instantiates it and one rbr_add instance.

Test Plan:
- Reset check: assert rst 2 cycles with all req_valid=1 -> req_ready=0, rsp_valid=0, rsp_s=8'b01010101 (W=4), rsp_id=0.
- Single op, W=4, NREQ=4: req 2 sends a=8'b01011111 (+3), b=8'b01010111 (+1) with rsp_ready=1 -> accepted cycle t, rsp_valid at t+1, decoded rsp_s=+4, rsp_id=2.
- Round-robin under full load: all 4 requesters valid, rsp_ready=1 for 8 cycles -> grant order 0,1,2,3,0,1,2,3 with back-to-back rsp_valid.
- Back-pressure: result pending, rsp_ready=0 for 3 cycles -> req_ready=0, rsp_s/rsp_id stable. rsp_ready=1 -> drain and next accept in the same cycle.
- Wrap and modular sum: a=8'b11111111 (+15), b=8'b01010111 (+1) -> decoded rsp_s ≡ 0 mod 16. Pointer after accept from requester 3 equals 0.
- Mid-operation reset: rst while rsp_valid=1 & rsp_ready=0 -> next cycle rsp_valid=0, pointer=0, and requester 0 is granted first afterwards.
